// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [1:0] {C_NONE, C_MISAL, C_RANGE} cause_e;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} dmem_state_e;

    // Access width in bytes for a size code.
    function automatic logic [3:0] size_bytes(size_e sz);
        unique case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between right-justified core data and 64-bit storage doublewords.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdword_i,
    output logic [7:0]  byte_en_o,
    output logic [63:0] wdword_o,
    output logic [63:0] rdata_o
);

    logic [5:0]  shamt;
    logic [7:0]  lane_mask;
    logic [63:0] size_mask;

    // Lane mask, write shift and read extract/mask from size and byte offset.
    always_comb begin
        shamt = {off_i, 3'b000};
        unique case (size_e'(size_i))
            SZ_B: begin lane_mask = 8'h01; size_mask = 64'h0000_0000_0000_00FF; end
            SZ_H: begin lane_mask = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; end
            SZ_W: begin lane_mask = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin lane_mask = 8'hFF; size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        // Misaligned accesses may shift lanes out; they never write, so that is harmless.
        byte_en_o = lane_mask << off_i;
        wdword_o  = wdata_i << shamt;
        rdata_o   = (rdword_i >> shamt) & size_mask;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: request latch, wait-state FSM, fault checker and doubleword storage.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_DW    = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_cause
);

    localparam int unsigned IdxW      = $clog2(DEPTH_DW);
    localparam logic [63:0] SpanBytes = 64'(DEPTH_DW) * 64'd8;
    localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);

    logic [63:0] mem [DEPTH_DW];

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    size_e       size_q, size_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    cause_e      cause_q, cause_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    cause_e      rsp_cause_q, rsp_cause_d;

    logic [63:0] req_off;
    cause_e      req_cause;
    logic        in_idle, enter_resp, mem_we;
    logic        cur_we;
    size_e       cur_size;
    logic [63:0] cur_addr, cur_wdata, cur_off;
    cause_e      cur_cause;
    logic [IdxW-1:0] mem_idx;
    logic [7:0]  byte_en;
    logic [63:0] wdword, lane_rdata;

    // Reset gates ready so nothing is offered while the block is held in reset.
    assign req_ready = rst && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_cause = rsp_cause_q;

    // Fault check on the incoming request; misalignment outranks range.
    always_comb begin
        req_off   = req_addr - BASE_ADDR;
        req_cause = C_NONE;
        if ((req_addr[2:0] & 3'(size_bytes(size_e'(req_size)) - 4'd1)) != 3'b000) begin
            req_cause = C_MISAL;
        end else if ((req_addr < BASE_ADDR) || (req_off >= SpanBytes)) begin
            req_cause = C_RANGE;
        end
    end

    // Effective request: live inputs when accepting in IDLE (zero-wait path), else the latch.
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        cur_we    = in_idle ? req_we : we_q;
        cur_size  = in_idle ? size_e'(req_size) : size_q;
        cur_addr  = in_idle ? req_addr : addr_q;
        cur_wdata = in_idle ? req_wdata : wdata_q;
        cur_cause = in_idle ? req_cause : cause_q;
        cur_off   = cur_addr - BASE_ADDR;
        mem_idx   = IdxW'(cur_off >> 3);
    end

    dmem_lane_align u_lane_align (
        .size_i    (cur_size),
        .off_i     (cur_addr[2:0]),
        .wdata_i   (cur_wdata),
        .rdword_i  (mem[mem_idx]),
        .byte_en_o (byte_en),
        .wdword_o  (wdword),
        .rdata_o   (lane_rdata)
    );

    // Next-state, request latch and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cause_d     = cause_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_cause_d = rsp_cause_q;
        enter_resp  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cause_d = req_cause;
                    if (WaitInit == 4'd0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WaitInit;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_rdata_d = 64'h0;
                    rsp_err_d   = 1'b0;
                    rsp_cause_d = C_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            rsp_err_d   = (cur_cause != C_NONE);
            rsp_cause_d = cur_cause;
            rsp_rdata_d = (cur_we || (cur_cause != C_NONE)) ? 64'h0 : lane_rdata;
        end
        mem_we = enter_resp && cur_we && (cur_cause == C_NONE);
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            addr_q      <= 64'h0;
            wdata_q     <= 64'h0;
            cause_q     <= C_NONE;
            rsp_rdata_q <= 64'h0;
            rsp_err_q   <= 1'b0;
            rsp_cause_q <= C_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cause_q     <= cause_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_cause_q <= rsp_cause_d;
        end
    end

    // Storage write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[mem_idx][8*i +: 8] <= wdword[8*i +: 8];
                end
            end
        end
    end

endmodule
